pwm_gen: RTL and testbench
==========================

Name: pwm_gen

Overview:
- Single-channel, free-running pulse-width modulator. Produces a square wave `sclk` whose high time per period equals the programmed `duty` count.
- Period is MAX_COUNT clock cycles, so the default gives 255 cycles = 2550 ns at a 100 MHz `clk`.
- Used as a brightness/speed/audio-level driver fed by a CPU output register.
- Duty updates are applied only at period boundaries, so the output never glitches mid-period.

Parameters:
- MAX_COUNT, 255: period length in `clk` cycles; must be ≥ 1. Duty ≥ MAX_COUNT means 100 %.
- DUTY_W, 16: width of the `duty` input.
- CNT_W, derived as $clog2(MAX_COUNT+1): internal counter width; not user-set.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  run enable. When low, the counter holds and `sclk` is forced low.
- duty  in  DUTY_W  requested high-time in cycles (0..MAX_COUNT); sampled once per period.
- sclk  out  1  PWM output, registered.
- period_start  out  1  one-cycle pulse, high in the cycle where count == 0 while enabled.
- count  out  CNT_W  current counter value, for debug and sync.

Behaviour:
- State: counter `cnt` (CNT_W bits), latched duty `duty_q` (CNT_W bits), and registers for `sclk` and `period_start`.
- Reset (rst=1 at an edge):
  - cnt=0, duty_q=0, sclk=0, period_start=0.
  - The first period after reset therefore outputs low.
  - Reset mid-period aborts the period immediately.
- Enabled, at each edge:
  - If cnt == MAX_COUNT-1: cnt→0 and duty_q ← min(duty, MAX_COUNT). This is the only point where duty is captured.
  - Otherwise: cnt → cnt+1.
- Output relation: sclk and period_start are registered from next-state values. In every cycle with en=1 (since the previous edge), `sclk == (cnt < duty_q)` and `period_start == (cnt == 0)`.
  - No combinational path exists from the inputs to the outputs.
- Duty boundaries:
  - duty=0: sclk is constantly low.
  - duty=D with 0 < D < MAX_COUNT: sclk is high for exactly D consecutive cycles starting at cnt=0, then low for MAX_COUNT-D cycles.
  - duty ≥ MAX_COUNT, including any value up to 2^DUTY_W-1: clamped to MAX_COUNT, so sclk is constantly high with no low cycle at wrap.
- Wrap-around: the period is exactly MAX_COUNT cycles; cnt never reaches MAX_COUNT.
- `duty` changing mid-period has no effect until the next wrap.
- en=0, at each edge:
  - cnt and duty_q hold.
  - sclk=0 and period_start=0 (registered, so low from the next cycle).
  - On re-enable, counting resumes from the held cnt.
- rst has priority over en.
- Arithmetic:
  - Compare with an unsigned less-than on CNT_W bits, after clamping `duty` in DUTY_W bits.
  - The clamp must not truncate before comparing; e.g. duty=256 must not become 0.
- MAX_COUNT=1 edge case: period is 1 cycle; sclk equals (duty_q ≥ 1).

Decomposition:
- Shared package `pwm_pkg`:
  - Default MAX_COUNT and DUTY_W localparams.
  - A `clamp_duty` function (DUTY_W → CNT_W saturation).
- One natural sub-module, `pwm_counter`: the modulo-MAX_COUNT counter with enable, synchronous reset and a wrap flag.
- The top level holds the duty latch and the output compare registers.

Test Plan:
- Reset, then duty=0, en=1, 600 cycles → sclk never high; period_start pulses every 255 cycles.
- duty=128 held, skip the first period after reset → each 255-cycle period has exactly 128 high cycles followed by 127 low; the rising edge coincides with the period_start cycle.
- Sweep duty 0..255, changing every 2550 ns (255 cycles) → high count per period is monotone and equals the duty captured at the preceding wrap. 255 gives all-high; 0 gives all-low.
- duty=300 and duty=16'hFFFF → clamped; sclk constantly high across a wrap, never truncated to low.
- Duty changed from 50 to 200 at cnt=100 → the current period keeps 50 high cycles; the next period has 200.
- rst asserted at cnt=70 with duty=200, and en low for 40 cycles mid-period:
  - rst → next cycle cnt=0, sclk=0, duty_q=0.
  - en low → sclk low and count frozen; on re-enable, resumes from the frozen count with unchanged duty_q.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults and duty saturation helper for the PWM generator.
package pwm_pkg;

  localparam int unsigned DefMaxCount = 255;
  localparam int unsigned DefDutyW    = 16;

  // Saturate a requested duty to the period length. The compare is done on the
  // full 32-bit value so wide requests (e.g. 256) never wrap to a small count.
  function automatic logic [31:0] clamp_duty(input logic [31:0] duty,
                                             input int unsigned max_count);
    return (duty >= max_count) ? max_count : duty;
  endfunction

endpackage

// File: rtl/pwm_counter.sv
// Modulo-MaxCount period counter with enable, synchronous reset and wrap flag.
module pwm_counter #(
  parameter int unsigned MaxCount = 255,
  parameter int unsigned CntW     = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic [CntW-1:0] cnt_next_o,
  output logic            wrap_o
);

  localparam logic [CntW-1:0] LastCnt = CntW'(MaxCount - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    wrap_o = en_i && (cnt_q == LastCnt);
    cnt_d  = cnt_q;
    if (en_i) begin
      cnt_d = wrap_o ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/pwm_gen.sv
// Free-running single-channel PWM; duty is latched only at the period wrap so
// the output never glitches mid-period. Outputs are registered from next state.
module pwm_gen
  import pwm_pkg::*;
#(
  parameter  int unsigned MAX_COUNT = DefMaxCount,
  parameter  int unsigned DUTY_W    = DefDutyW,
  localparam int unsigned CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DUTY_W-1:0] duty,
  output logic              sclk,
  output logic              period_start,
  output logic [CNT_W-1:0]  count
);

  logic [CNT_W-1:0] cnt, cnt_next;
  logic             wrap;
  logic [CNT_W-1:0] duty_clamped;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic             sclk_q, sclk_d;
  logic             period_start_q, period_start_d;

  pwm_counter #(
    .MaxCount (MAX_COUNT),
    .CntW     (CNT_W)
  ) u_counter (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .cnt_o      (cnt),
    .cnt_next_o (cnt_next),
    .wrap_o     (wrap)
  );

  // Clamped value is at most MAX_COUNT, so narrowing to CNT_W is lossless.
  assign duty_clamped = CNT_W'(clamp_duty(32'(duty), MAX_COUNT));

  always_comb begin
    duty_d = duty_q;
    if (wrap) begin
      duty_d = duty_clamped;
    end
    sclk_d         = en && (cnt_next < duty_d);
    period_start_d = en && (cnt_next == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      duty_q         <= '0;
      sclk_q         <= 1'b0;
      period_start_q <= 1'b0;
    end else begin
      duty_q         <= duty_d;
      sclk_q         <= sclk_d;
      period_start_q <= period_start_d;
    end
  end

  assign sclk         = sclk_q;
  assign period_start = period_start_q;
  assign count        = cnt;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed self-checking bench for pwm_gen with the default 255-cycle period.
module tb_pwm_gen;

  localparam int unsigned MaxCount = 255;
  localparam int unsigned DutyW    = 16;
  localparam int unsigned CntW     = $clog2(MaxCount + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [DutyW-1:0] duty;
  logic             sclk;
  logic             period_start;
  logic [CntW-1:0]  count;

  int n_assert = 0;
  int n_fail   = 0;

  int hi, glitch, pulses, first_pulse, prev;
  bit found;
  int sweep [6] = '{0, 1, 2, 127, 254, 255};

  pwm_gen #(
    .MAX_COUNT (MaxCount),
    .DUTY_W    (DutyW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .duty         (duty),
    .sclk         (sclk),
    .period_start (period_start),
    .count        (count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Samples one full period starting at the current cnt==0 sample, optionally
  // changing duty partway through. Counts high cycles and any low-to-high return.
  task automatic run_period(input int chg_at, input logic [DutyW-1:0] chg_val,
                            output int hi_o, output int glitch_o);
    bit seen_low = 0;
    hi_o = 0;
    glitch_o = 0;
    for (int i = 0; i < int'(MaxCount); i++) begin
      if (i == chg_at) duty = chg_val;
      if (sclk === 1'b1) begin
        hi_o++;
        if (seen_low) glitch_o++;
      end else begin
        seen_low = 1;
      end
      step(1);
    end
  endtask

  initial begin
    // Reset state
    rst = 1'b1; en = 1'b0; duty = '0;
    step(2);
    check("rst_count", 32'(count), 0);
    check("rst_sclk", 32'(sclk), 0);
    check("rst_period_start", 32'(period_start), 0);

    // duty=0 for 600 cycles
    rst = 1'b0; en = 1'b1;
    hi = 0; pulses = 0; first_pulse = -1;
    for (int i = 1; i <= 600; i++) begin
      step(1);
      if (sclk === 1'b1) hi++;
      if (period_start === 1'b1) begin
        pulses++;
        if (first_pulse < 0) first_pulse = i;
      end
    end
    check("duty0_high_cycles", 32'(hi), 0);
    check("duty0_pulses", 32'(pulses), 2);
    check("duty0_first_pulse", 32'(first_pulse), 255);
    check("duty0_count_after_600", 32'(count), 90);

    // duty=128: wait for the wrap that captures it
    duty = 16'd128;
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      step(1);
      if (period_start === 1'b1) found = 1;
    end
    check("wait_period_start", 32'(found), 1);
    check("d128_wrap_count", 32'(count), 0);
    check("d128_rise_at_start", 32'(sclk), 1);
    for (int p = 0; p < 2; p++) begin
      run_period(-1, '0, hi, glitch);
      check("d128_high_cycles", 32'(hi), 128);
      check("d128_contiguous", 32'(glitch), 0);
    end

    // Sweep: each period reflects the duty presented during the previous one
    prev = 128;
    foreach (sweep[k]) begin
      duty = DutyW'(sweep[k]);
      run_period(-1, '0, hi, glitch);
      check("sweep_high_cycles", 32'(hi), 32'(prev));
      check("sweep_contiguous", 32'(glitch), 0);
      prev = sweep[k];
    end
    duty = 16'd300;
    run_period(-1, '0, hi, glitch);
    check("sweep_last_255", 32'(hi), 255);

    // Clamp of oversize requests
    duty = 16'hFFFF;
    run_period(-1, '0, hi, glitch);
    check("clamp_300", 32'(hi), 255);
    check("clamp_300_wrap_high", 32'(sclk), 1);
    duty = 16'd50;
    run_period(-1, '0, hi, glitch);
    check("clamp_ffff", 32'(hi), 255);
    check("clamp_ffff_wrap_high", 32'(sclk), 1);

    // Mid-period duty change 50 -> 200 at cnt=100
    run_period(100, 16'd200, hi, glitch);
    check("midchg_current_50", 32'(hi), 50);
    run_period(-1, '0, hi, glitch);
    check("midchg_next_200", 32'(hi), 200);

    // Reset at cnt=70 with duty_q=200
    step(70);
    check("pre_rst_count", 32'(count), 70);
    check("pre_rst_sclk", 32'(sclk), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("post_rst_count", 32'(count), 0);
    check("post_rst_sclk", 32'(sclk), 0);
    check("post_rst_period_start", 32'(period_start), 0);
    run_period(-1, '0, hi, glitch);
    check("post_rst_period_low", 32'(hi), 0);
    check("post_rst_recapture", 32'(sclk), 1);

    // en low for 40 cycles at cnt=30
    step(30);
    check("pre_dis_count", 32'(count), 30);
    en = 1'b0;
    duty = 16'd10;
    step(1);
    check("dis_count_frozen", 32'(count), 30);
    check("dis_sclk_low", 32'(sclk), 0);
    step(39);
    check("dis_count_still", 32'(count), 30);
    check("dis_sclk_still", 32'(sclk), 0);
    check("dis_period_start", 32'(period_start), 0);
    en = 1'b1;
    step(1);
    check("reen_count", 32'(count), 31);
    check("reen_sclk", 32'(sclk), 1);
    step(168);
    check("reen_last_high", 32'(sclk), 1);
    step(1);
    check("reen_fall_count", 32'(count), 200);
    check("reen_fall_sclk", 32'(sclk), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
